// File: rtl/i2cm2_pkg.sv
// Shared constants for the second-generation I2C master register file:
// register offsets, interrupt bit positions, CTRL fields and parameter limits.
package i2cm2_pkg;

    typedef enum logic [3:0] {
        OFF_DEVICE_ID  = 4'h0,
        OFF_OFFSET     = 4'h1,
        OFF_LEN_LSB    = 4'h2,
        OFF_LEN_MSB    = 4'h3,
        OFF_CTRL       = 4'h4,
        OFF_DATA       = 4'h5,
        OFF_TFIFO_FREE = 4'h6,
        OFF_RFIFO_CNT  = 4'h7,
        OFF_FIFO_CLR   = 4'h8,
        OFF_TP_LSB     = 4'h9,
        OFF_TP_MSB     = 4'hA,
        OFF_STATE      = 4'hB,
        OFF_INT_STATUS = 4'hC,
        OFF_INT_EN     = 4'hD,
        OFF_RFIFO_THR  = 4'hE,
        OFF_TFIFO_THR  = 4'hF
    } reg_off_e;

    localparam int INT_DONE    = 0;
    localparam int INT_NACK    = 1;
    localparam int INT_TOVF    = 2;
    localparam int INT_RUDF    = 3;
    localparam int INT_RTHR    = 4;
    localparam int INT_TTHR    = 5;
    localparam int INT_CMD_ERR = 6;
    localparam int INT_BITS    = 7;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_START = 1;
    localparam int CTRL_NOD   = 2;
    localparam int CTRL_TT_LO = 4;
    localparam int CTRL_TT_HI = 6;

    localparam int FIFO_CLR_T = 0;
    localparam int FIFO_CLR_R = 1;

    // A NACK seen in this byte-FSM state is expected and not reported.
    localparam logic [3:0] NACK_IGNORE_STATE = 4'd2;

    localparam int ADDR_WIDTH_MIN = 2;
    localparam int ADDR_WIDTH_MAX = 7;
    localparam int LEN_WIDTH_MIN  = 9;
    localparam int LEN_WIDTH_MAX  = 16;
    localparam int TP_WIDTH_MIN   = 9;
    localparam int TP_WIDTH_MAX   = 16;

endpackage

// File: rtl/i2cm2_irq.sv
// Interrupt block: FIFO threshold edge detectors, W1C status, enable mask
// and the registered irq output.
module i2cm2_irq
    import i2cm2_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_done,
    input  logic                i_nack,
    input  logic                i_tovf,
    input  logic                i_rudf,
    input  logic                i_cmd_err,
    input  logic [CW-1:0]       i_rcnt,
    input  logic [CW-1:0]       i_tfree,
    input  logic [CW-1:0]       i_rthr,
    input  logic [CW-1:0]       i_tthr,
    input  logic                i_status_wr,
    input  logic                i_int_en_wr,
    input  logic [7:0]          i_wdata,
    output logic [INT_BITS-1:0] o_status,
    output logic [INT_BITS-1:0] o_int_en,
    output logic                o_irq
);

    logic                w_rlvl;
    logic                w_tlvl;
    logic [INT_BITS-1:0] w_set;
    logic [INT_BITS-1:0] w_clr;
    logic                r_rlvl_d;
    logic                r_tlvl_d;
    logic [INT_BITS-1:0] r_status;
    logic [INT_BITS-1:0] r_int_en;
    logic                r_irq;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_set  = '0;
        w_clr  = '0;
        w_rlvl = (i_rthr != '0) && (i_rcnt >= i_rthr);
        w_tlvl = (i_tthr != '0) && (i_tfree >= i_tthr);
        w_set[INT_DONE]    = i_done;
        w_set[INT_NACK]    = i_nack;
        w_set[INT_TOVF]    = i_tovf;
        w_set[INT_RUDF]    = i_rudf;
        w_set[INT_RTHR]    = w_rlvl & ~r_rlvl_d;
        w_set[INT_TTHR]    = w_tlvl & ~r_tlvl_d;
        w_set[INT_CMD_ERR] = i_cmd_err;
        if (i_status_wr) begin
            w_clr = i_wdata[INT_BITS-1:0];
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rlvl_d <= 1'b0;
            r_tlvl_d <= 1'b0;
            r_status <= '0;
            r_int_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (i_int_en_wr) begin
                r_int_en <= i_wdata[INT_BITS-1:0];
            end
            if (!i_en) begin
                r_status <= '0;
                r_rlvl_d <= 1'b0;
                r_tlvl_d <= 1'b0;
            end else begin
                // Set is OR-ed after the clear so a coincident event survives the W1C.
                r_status <= (r_status & ~w_clr) | w_set;
                r_rlvl_d <= w_rlvl;
                r_tlvl_d <= w_tlvl;
            end
            r_irq <= |(r_status & r_int_en);
        end
    end

    assign o_status = r_status;
    assign o_int_en = r_int_en;
    assign o_irq    = r_irq;

endmodule

// File: rtl/i2cm2_regfile.sv
// RAB-side register file for the I2C master: address decode, configuration
// registers, start/busy tracking and registered readback.
module i2cm2_regfile
    import i2cm2_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int LEN_WIDTH  = 10,
    parameter int TP_WIDTH   = 10,
    parameter int TP_RESET   = 20
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [4:0]            baseaddr,
    input  logic                  i2cm_wr,
    input  logic                  i2cm_rd,
    input  logic [8:0]            rab_addr,
    input  logic [7:0]            i2cm_wdata,
    input  logic [7:0]            rfifo_data_to_reg,
    input  logic                  rfifo_empty,
    input  logic                  tfifo_empty,
    input  logic [ADDR_WIDTH:0]   tfifo_freecnt,
    input  logic [ADDR_WIDTH:0]   rfifo_wordcnt,
    input  logic                  fsm_using,
    input  logic                  slave_waiting,
    input  logic                  non_ack,
    input  logic                  tfifo_overflow,
    input  logic                  rfifo_underflow,
    input  logic                  sto_condition,
    input  logic [3:0]            byte_fsm_status,
    output logic [7:0]            i2cm_rdata,
    output logic                  i2cm_ack,
    output logic                  tfifo_push,
    output logic                  rfifo_pop,
    output logic [7:0]            tfifo_data_from_reg,
    output logic [7:0]            device_id_seg,
    output logic [7:0]            offset,
    output logic [LEN_WIDTH-1:0]  data_len,
    output logic [TP_WIDTH-1:0]   timing_para,
    output logic                  i2c_en,
    output logic                  start,
    output logic                  opendrain,
    output logic                  tfifo_en,
    output logic                  rfifo_en,
    output logic [2:0]            trans_type,
    output logic                  irq
);

    localparam int CW = ADDR_WIDTH + 1;

    if (ADDR_WIDTH < ADDR_WIDTH_MIN || ADDR_WIDTH > ADDR_WIDTH_MAX) begin : g_bad_addr_width
        $error("i2cm2_regfile: ADDR_WIDTH out of range");
    end
    if (LEN_WIDTH < LEN_WIDTH_MIN || LEN_WIDTH > LEN_WIDTH_MAX) begin : g_bad_len_width
        $error("i2cm2_regfile: LEN_WIDTH out of range");
    end
    if (TP_WIDTH < TP_WIDTH_MIN || TP_WIDTH > TP_WIDTH_MAX) begin : g_bad_tp_width
        $error("i2cm2_regfile: TP_WIDTH out of range");
    end

    logic                 w_sel;
    logic                 w_wr;
    logic                 w_rd;
    reg_off_e             w_off;
    logic                 w_start_req;
    logic                 w_start_ok;
    logic                 w_cmd_err;
    logic [7:0]           w_rdata;
    logic [INT_BITS-1:0]  w_status;
    logic [INT_BITS-1:0]  w_int_en;
    logic                 w_irq;

    logic [7:0]           r_device_id;
    logic [7:0]           r_offset;
    logic [LEN_WIDTH-1:0] r_len;
    logic [TP_WIDTH-1:0]  r_tp;
    logic                 r_i2c_en;
    logic                 r_start;
    logic                 r_nod;
    logic [2:0]           r_tt;
    logic                 r_tclr;
    logic                 r_rclr;
    logic                 r_busy;
    logic [CW-1:0]        r_rthr;
    logic [CW-1:0]        r_tthr;
    logic [7:0]           r_rdata;
    logic                 r_ack;

    assign w_sel       = (rab_addr[8:4] == baseaddr);
    assign w_off       = reg_off_e'(rab_addr[3:0]);
    assign w_wr        = i2cm_wr & w_sel;
    assign w_rd        = i2cm_rd & w_sel;
    assign w_start_req = w_wr && (w_off == OFF_CTRL) && i2cm_wdata[CTRL_START];
    assign w_start_ok  = w_start_req & i2cm_wdata[CTRL_EN] & ~r_busy;
    assign w_cmd_err   = w_start_req & r_busy;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_device_id <= '0;
            r_offset    <= '0;
            r_len       <= '0;
            r_tp        <= TP_WIDTH'(TP_RESET);
            r_i2c_en    <= 1'b0;
            r_start     <= 1'b0;
            r_nod       <= 1'b0;
            r_tt        <= '0;
            r_tclr      <= 1'b0;
            r_rclr      <= 1'b0;
            r_busy      <= 1'b0;
            r_rthr      <= '0;
            r_tthr      <= '0;
        end else begin
            r_start <= w_start_ok;
            r_tclr  <= 1'b0;
            r_rclr  <= 1'b0;
            if (w_wr) begin
                case (w_off)
                    OFF_DEVICE_ID: r_device_id <= i2cm_wdata;
                    OFF_OFFSET:    r_offset    <= i2cm_wdata;
                    OFF_LEN_LSB:   r_len[7:0]  <= i2cm_wdata;
                    OFF_LEN_MSB:   r_len[LEN_WIDTH-1:8] <= i2cm_wdata[LEN_WIDTH-9:0];
                    OFF_CTRL: begin
                        r_i2c_en <= i2cm_wdata[CTRL_EN];
                        r_nod    <= i2cm_wdata[CTRL_NOD];
                        r_tt     <= i2cm_wdata[CTRL_TT_HI:CTRL_TT_LO];
                    end
                    OFF_FIFO_CLR: begin
                        r_tclr <= i2cm_wdata[FIFO_CLR_T];
                        r_rclr <= i2cm_wdata[FIFO_CLR_R];
                    end
                    OFF_TP_LSB:    r_tp[7:0]  <= i2cm_wdata;
                    OFF_TP_MSB:    r_tp[TP_WIDTH-1:8] <= i2cm_wdata[TP_WIDTH-9:0];
                    OFF_RFIFO_THR: r_rthr <= i2cm_wdata[CW-1:0];
                    OFF_TFIFO_THR: r_tthr <= i2cm_wdata[CW-1:0];
                    default: ;
                endcase
            end
            // An accepted start wins over a stop or disable seen in the same cycle.
            if (w_start_ok) begin
                r_busy <= 1'b1;
            end else if (sto_condition || !r_i2c_en) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_DEVICE_ID:  w_rdata = r_device_id;
            OFF_OFFSET:     w_rdata = r_offset;
            OFF_LEN_LSB:    w_rdata = r_len[7:0];
            OFF_LEN_MSB:    w_rdata[LEN_WIDTH-9:0] = r_len[LEN_WIDTH-1:8];
            OFF_CTRL:       w_rdata = {1'b0, r_tt, 1'b0, r_nod, r_start, r_i2c_en};
            OFF_DATA:       w_rdata = rfifo_data_to_reg;
            OFF_TFIFO_FREE: w_rdata[CW-1:0] = tfifo_freecnt;
            OFF_RFIFO_CNT:  w_rdata[CW-1:0] = rfifo_wordcnt;
            OFF_FIFO_CLR:   w_rdata[7:4] = byte_fsm_status;
            OFF_TP_LSB:     w_rdata = r_tp[7:0];
            OFF_TP_MSB:     w_rdata[TP_WIDTH-9:0] = r_tp[TP_WIDTH-1:8];
            OFF_STATE:      w_rdata = {3'b000, slave_waiting, fsm_using,
                                       tfifo_empty, ~rfifo_empty, r_busy};
            OFF_INT_STATUS: w_rdata[INT_BITS-1:0] = w_status;
            OFF_INT_EN:     w_rdata[INT_BITS-1:0] = w_int_en;
            OFF_RFIFO_THR:  w_rdata[CW-1:0] = r_rthr;
            OFF_TFIFO_THR:  w_rdata[CW-1:0] = r_tthr;
            default:        w_rdata = '0;
        endcase
    end

    // NOTE: only control and data-path registers carry the async reset; no memories here.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rdata <= '0;
            r_ack   <= 1'b0;
        end else begin
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
            r_ack <= w_wr | w_rd;
        end
    end

    i2cm2_irq #(
        .CW (CW)
    ) u_irq (
        .i_clk       (sys_clk),
        .i_rst       (sys_rst),
        .i_en        (r_i2c_en),
        .i_done      (sto_condition & r_busy),
        .i_nack      (non_ack && (byte_fsm_status != NACK_IGNORE_STATE)),
        .i_tovf      (tfifo_overflow),
        .i_rudf      (rfifo_underflow),
        .i_cmd_err   (w_cmd_err),
        .i_rcnt      (rfifo_wordcnt),
        .i_tfree     (tfifo_freecnt),
        .i_rthr      (r_rthr),
        .i_tthr      (r_tthr),
        .i_status_wr (w_wr && (w_off == OFF_INT_STATUS)),
        .i_int_en_wr (w_wr && (w_off == OFF_INT_EN)),
        .i_wdata     (i2cm_wdata),
        .o_status    (w_status),
        .o_int_en    (w_int_en),
        .o_irq       (w_irq)
    );

    assign i2cm_rdata          = r_rdata;
    assign i2cm_ack            = r_ack;
    assign tfifo_push          = w_wr && (w_off == OFF_DATA);
    assign rfifo_pop           = w_rd && (w_off == OFF_DATA);
    assign tfifo_data_from_reg = i2cm_wdata;
    assign device_id_seg       = r_device_id;
    assign offset              = r_offset;
    assign data_len            = r_len;
    assign timing_para         = r_tp;
    assign i2c_en              = r_i2c_en;
    assign start               = r_start;
    assign opendrain           = ~r_nod;
    assign tfifo_en            = r_i2c_en & ~r_tclr;
    assign rfifo_en            = r_i2c_en & ~r_rclr;
    assign trans_type          = r_tt;
    assign irq                 = w_irq;

endmodule

// File: doc/i2cm2_regfile.md
# i2cm2_regfile

Second-generation register file for the I2C master, sitting between the RAB register bus and the byte/transaction FSM plus TX/RX FIFOs. Widens the FIFO depth, data length and timing fields under parameters. Adds FIFO threshold detection, a masked write-1-clear interrupt status register with a registered `irq` output, and start-while-busy command-error detection. Registered read data and acknowledge are kept so bus-side software stays compatible.

## Interface
- ADDR_WIDTH, 3, FIFO address bits; counts are ADDR_WIDTH+1 bits; legal 2..7
- LEN_WIDTH, 10, transaction length bits; legal 9..16
- TP_WIDTH, 10, timing parameter bits; legal 9..16
- TP_RESET, 20, reset value of timing_para
- sys_clk  in  1  system clock
- sys_rst  in  1  reset; one clock; reset is asynchronous and active-high
- baseaddr  in  5  block select, compared with rab_addr[8:4]
- i2cm_wr / i2cm_rd  in  1  bus write / read strobe
- rab_addr  in  9  bus address
- i2cm_wdata  in  8  write data
- rfifo_data_to_reg  in  8  RX FIFO head
- rfifo_empty, tfifo_empty  in  1  FIFO flags
- tfifo_freecnt, rfifo_wordcnt  in  ADDR_WIDTH+1  FIFO occupancy
- fsm_using, slave_waiting, non_ack, tfifo_overflow, rfifo_underflow, sto_condition  in  1  engine events
- byte_fsm_status  in  4  byte FSM state
- i2cm_rdata  out  8  registered read data
- i2cm_ack  out  1  access acknowledge
- tfifo_push, rfifo_pop  out  1  combinational FIFO strobes
- tfifo_data_from_reg  out  8  equals i2cm_wdata
- device_id_seg, offset  out  8  config
- data_len  out  LEN_WIDTH  config
- timing_para  out  TP_WIDTH  config
- i2c_en, start, opendrain, tfifo_en, rfifo_en  out  1  control
- trans_type  out  3  transaction type
- irq  out  1  interrupt, active-high level

## Operation
- sel = (rab_addr[8:4]==baseaddr). Offsets:
  - 0 DEVICE_ID
  - 1 OFFSET
  - 2 LEN_LSB
  - 3 LEN_MSB (bits LEN_WIDTH-9:0)
  - 4 CTRL (0 en, 1 start, 2 nonopendrain, 6:4 trans_type)
  - 5 DATA (write pushes, read pops)
  - 6 TFIFO_FREE (RO)
  - 7 RFIFO_CNT (RO)
  - 8 FIFO_CLR (0 tclr, 1 rclr; read [7:4]=byte_fsm_status)
  - 9 TP_LSB
  - A TP_MSB
  - B STATE (RO: 0 busy, 1 ~rfifo_empty, 2 tfifo_empty, 3 fsm_using, 4 slave_waiting)
  - C INT_STATUS (W1C)
  - D INT_EN
  - E RFIFO_THR
  - F TFIFO_THR
- Unused or unimplemented bits read 0 and ignore writes.
- start, tfifo_clr, rfifo_clr: one-cycle self-clearing pulses.
- Start is accepted on a CTRL write with wdata[1]=1, wdata[0]=1 and busy=0. An accepted start pulses start and sets busy.
- Start requested while busy=1: no pulse, busy unchanged, cmd_err set. Other CTRL fields are still written.
- busy clears on sto_condition or i2c_en=0.
- INT_STATUS bits, each set by its event and cleared by writing 1:
  - 0 done: sto_condition while busy
  - 1 nack: non_ack and byte_fsm_status!=2
  - 2 tfifo_overflow
  - 3 rfifo_underflow
  - 4 rthr: rising edge of (rfifo_wordcnt>=RFIFO_THR and RFIFO_THR!=0)
  - 5 tthr: rising edge of (tfifo_freecnt>=TFIFO_THR and TFIFO_THR!=0)
  - 6 cmd_err
  - 7 reads 0
- If set and W1C happen in the same cycle, set wins.
- i2c_en=0 clears all status bits and the edge-detect history.
- irq = registered |(INT_STATUS & INT_EN).
- opendrain = ~nonopendrain.
- tfifo_en = i2c_en & ~tfifo_clr; rfifo_en = i2c_en & ~rfifo_clr.
- tfifo_push = i2cm_wr & sel & offset 5; rfifo_pop = i2cm_rd & sel & offset 5.

## Timing
- Reset values:
  - all registers, rdata, ack, irq, busy and status bits = 0
  - timing_para = TP_RESET
  - opendrain = 1
  - tfifo_en = rfifo_en = 0
- Write takes effect on the clock edge of the strobe; start is high the following cycle only.
- i2cm_ack and i2cm_rdata are valid 1 cycle after the strobe. ack is asserted for any selected access, including unmapped bits.
- FIFO read data is sampled in the pop cycle.
- irq follows a status change by 1 cycle.
- Simultaneous wr and rd: both honoured.
- Reset mid-transaction returns everything to reset values immediately, with no pending pulses.

## Structure
- Package i2cm2_pkg holds:
  - 4-bit offset constants
  - INT_STATUS bit indices
  - CTRL field positions
  - parameter legality limits
- Sub-module i2cm2_irq holds the threshold edge detectors, INT_STATUS/INT_EN, the W1C logic and the irq register. The parent handles decode, config registers, busy and readback.

## Test plan
- Reset, then read every offset → timing_para readback 0x14/0x00 (TP_RESET default), all others 0, ack one cycle after each rd.
- LEN_WIDTH=16: write LEN 0xFF then 0xFF, read LSB/MSB → 0xFF/0xFF, data_len=0xFFFF. With LEN_WIDTH=10 the MSB reads 0x03.
- CTRL=0x03 → start pulses 1 cycle, busy=1. Second CTRL=0x03 → no start, INT_STATUS=0x40. sto_condition → busy=0, bit0 set.
- RFIFO_THR=4, INT_EN=0x10, rfifo_wordcnt steps 3→4 → irq=1 one cycle later. Write INT_STATUS=0x10 → irq=0. Count held at 5 → no re-set.
- non_ack with byte_fsm_status=2 → no status. With status=5 and a simultaneous W1C of bit1 → bit1 stays 1.
- FIFO_CLR=0x03 → tfifo_en/rfifo_en low exactly 1 cycle. i2c_en=0 → all status bits and irq cleared.
